// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter: FSM states, requester ids
// and the default wait-phase timeout.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_e;

  typedef enum logic {
    REQ_F = 1'b0,
    REQ_D = 1'b1
  } req_id_e;

  localparam int unsigned TIMEOUT_CYCLES_DEF = 64;

endpackage

// File: rtl/mem_arb_rr2.sv
// Two-way round-robin picker: a lone requester wins outright, a tie goes to
// whichever port was not granted last. The last grant updates on i_take.
module mem_arb_rr2
  import mem_arb_pkg::*;
(
  input  logic    clock,
  input  logic    reset,
  input  logic    i_f_req,
  input  logic    i_d_req,
  input  logic    i_take,
  output logic    o_valid,
  output req_id_e o_grant
);

  // Reset to data so that fetch wins the first tie.
  req_id_e r_last;

  // NOTE: every output of a combinational block gets a value on every path;
  // the trailing else is what keeps o_grant from becoming a latch.
  always_comb begin
    o_valid = i_f_req | i_d_req;
    if (i_f_req && i_d_req) begin
      o_grant = (r_last == REQ_D) ? REQ_F : REQ_D;
    end else if (i_d_req) begin
      o_grant = REQ_D;
    end else begin
      o_grant = REQ_F;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_last <= REQ_D;
    end else if (i_take) begin
      r_last <= o_grant;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a read-only fetch port and a read/write data port onto one
// handshake memory (strobe, then mem_ready high-then-low), with a timeout.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        f_req,
  input  logic [15:0] f_addr,
  output logic [15:0] f_rdata,
  output logic        f_done,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic [15:0] d_rdata,
  output logic        d_done,
  output logic        err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_e           r_state;
  req_id_e          r_owner;
  logic             r_we;
  logic [CNT_W-1:0] r_cnt;

  logic    w_valid;
  logic    w_take;
  logic    w_cnt_max;
  req_id_e w_grant;

  assign w_take    = (r_state == IDLE) && w_valid;
  assign w_cnt_max = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  mem_arb_rr2 u_rr2 (
    .clock   (clock),
    .reset   (reset),
    .i_f_req (f_req),
    .i_d_req (d_req),
    .i_take  (w_take),
    .o_valid (w_valid),
    .o_grant (w_grant)
  );

  // NOTE: all state and registered outputs use non-blocking assignments so
  // every branch below reads the values from before this clock edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_owner   <= REQ_F;
      r_we      <= 1'b0;
      r_cnt     <= '0;
      err       <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      f_rdata   <= '0;
      d_rdata   <= '0;
      f_done    <= 1'b0;
      d_done    <= 1'b0;
    end else begin
      f_done <= 1'b0;
      d_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_owner <= w_grant;
            if (w_grant == REQ_D) begin
              r_we      <= d_we;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              mem_read  <= ~d_we;
              mem_write <= d_we;
            end else begin
              r_we      <= 1'b0;
              mem_addr  <= f_addr;
              mem_read  <= 1'b1;
            end
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          // A ready level seen here is left over from an earlier access.
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          r_cnt     <= '0;
          r_state   <= WAIT_HI;
        end
        WAIT_HI: begin
          if (mem_ready) begin
            if (!r_we) begin
              if (r_owner == REQ_F) f_rdata <= mem_rdata;
              else                  d_rdata <= mem_rdata;
            end
            f_done  <= (r_owner == REQ_F);
            d_done  <= (r_owner == REQ_D);
            r_cnt   <= '0;
            r_state <= WAIT_LO;
          end else if (w_cnt_max) begin
            err     <= 1'b1;
            f_done  <= (r_owner == REQ_F);
            d_done  <= (r_owner == REQ_D);
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        WAIT_LO: begin
          // Done has already pulsed on entry, so a stuck ready only flags err.
          if (!mem_ready) begin
            r_state <= IDLE;
          end else if (w_cnt_max) begin
            err     <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64: max cycles waiting on mem_ready per phase before abort.
REQ-002 clock  input  1  single system clock, all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 f_req  input  1  fetch-port request (read only), held until f_done.
REQ-005 f_addr  input  16  fetch address.
REQ-006 f_rdata  output  16  fetch read data, valid from f_done onward.
REQ-007 f_done  output  1  one-cycle fetch completion pulse.
REQ-008 d_req  input  1  data-port request, held until d_done.
REQ-009 d_we  input  1  data-port direction: 1 write, 0 read.
REQ-010 d_addr  input  16  data address.
REQ-011 d_wdata  input  16  data write value.
REQ-012 d_rdata  output  16  data read value, valid from d_done onward.
REQ-013 d_done  output  1  one-cycle data completion pulse.
REQ-014 err  output  1  sticky timeout flag.
REQ-015 mem_read  output  1  memory read strobe (to RAM read).
REQ-016 mem_write  output  1  memory write strobe (to RAM write).
REQ-017 mem_addr  output  16  memory address (to MAR).
REQ-018 mem_wdata  output  16  memory write data (to MDR_in).
REQ-019 mem_rdata  input  16  memory read data (from MDR), valid while mem_ready high.
REQ-020 mem_ready  input  1  memory ready level (from R), high >=1 cycle per access, then low.

Function
REQ-021 FSM states SHALL be IDLE, ISSUE, WAIT_HI, WAIT_LO.
REQ-022 IDLE: if any req high, grant one requester, latch its addr/wdata/direction, go to ISSUE next edge; else stay.
REQ-023 Arbitration: single requester granted directly; both high -> grant the one not granted last; after reset fetch wins first tie.
REQ-024 ISSUE lasts exactly one cycle: mem_read (fetch or d_we=0) or mem_write (d_we=1) high only in this cycle; then WAIT_HI.
REQ-025 mem_addr/mem_wdata SHALL hold latched values from ISSUE through WAIT_LO; mem_read=mem_write=0 in all other states.
REQ-026 WAIT_HI: on mem_ready=1, capture mem_rdata into owner's rdata (reads only), go to WAIT_LO.
REQ-027 Owner's done SHALL be high exactly in the first WAIT_LO cycle; other port's done stays 0.
REQ-028 WAIT_LO: on mem_ready=0 go to IDLE; minimum WAIT_LO length one cycle.
REQ-029 mem_ready high while in IDLE or ISSUE SHALL be ignored (stale).
REQ-030 Timeout counter resets on entry to WAIT_HI and WAIT_LO; reaching TIMEOUT_CYCLES sets err, pulses owner's done (if not yet pulsed), rdata unchanged, goes to IDLE.
REQ-031 req deasserted mid-transaction SHALL NOT abort; transaction completes, done still pulses.
REQ-032 Writes SHALL leave f_rdata/d_rdata unchanged.
REQ-033 Best-case latency: req in IDLE cycle N -> strobe N+1 -> mem_ready at N+2 -> done at N+3.

Reset
REQ-034 reset SHALL force IDLE, counter 0, last-grant = data (fetch wins next tie), err 0.
REQ-035 Outputs after reset: mem_read 0, mem_write 0, mem_addr 0, mem_wdata 0, f_rdata 0, d_rdata 0, f_done 0, d_done 0.
REQ-036 reset mid-transaction SHALL abandon it with no done pulse and no err.

Structure
REQ-037 Package mem_arb_pkg SHALL hold the state enum, requester-id enum (REQ_F, REQ_D) and TIMEOUT_CYCLES default.
REQ-038 One sub-module mem_arb_rr2 (2-way round-robin picker, last-grant register) is natural; counter and FSM stay in mem_arbiter.

Verification
REQ-039 f_req, f_addr=0x3000, model returns 0x5260 after 2 cycles, ready held 5 cycles -> one mem_read cycle, mem_addr=0x3000, f_rdata=0x5260, single f_done pulse.
REQ-040 d_req, d_we=1, d_addr=0x30FF, d_wdata=0x1234 -> one mem_write cycle, mem_wdata=0x1234, d_done pulse, d_rdata unchanged.
REQ-041 f_req and d_req both held from reset -> order fetch, data, fetch, data; no strobe overlap.
REQ-042 d_req read, mem_ready never asserts -> err=1 and d_done pulse 64 cycles after WAIT_HI entry, FSM back in IDLE.
REQ-043 reset pulsed during WAIT_HI -> strobes 0, no done, err 0, next f_req served normally.
REQ-044 mem_ready forced high in IDLE, no req -> no done, no strobe, state stays IDLE.
